// File: rtl/clb_cfg_loader.sv
// Serial configuration loader for one CLB: shifts a scan bitstream into the
// LUT SRAM write ports and mode bits of BLE_NUM BLEs, then bypasses scan bits downstream.

module clb_cfg_ble_slot (
  input  logic clk,
  input  logic rst_n,
  input  logic sel,
  input  logic mode_wr,
  input  logic lut_wr,
  input  logic bit_in,
  output logic is_comb,
  output logic we
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      is_comb <= 1'b0;
      we      <= 1'b0;
    end else begin
      we <= lut_wr & sel;
      if (mode_wr && sel) is_comb <= bit_in;
    end
  end
endmodule

module clb_cfg_loader #(
  parameter int LUT_WIDTH = 4,
  parameter int BLE_NUM   = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_start,
  input  logic                 scan_in,
  input  logic                 scan_en,
  output logic                 scan_out,
  output logic                 scan_out_en,
  output logic [BLE_NUM-1:0]   ble_we,
  output logic [LUT_WIDTH-1:0] ble_waddr,
  output logic                 ble_wdata,
  output logic [BLE_NUM-1:0]   is_comb,
  output logic                 cfg_busy,
  output logic                 cfg_done
);
  localparam int IW = (BLE_NUM > 1) ? $clog2(BLE_NUM) : 1;

  typedef enum logic [1:0] {IDLE, MODE, LUT, DONE} state_t;

  state_t               state, state_nx;
  logic [IW-1:0]        ble_idx;
  logic [LUT_WIDTH-1:0] lut_addr;
  logic                 start_ok, mode_wr, lut_wr, lut_last, ble_last, fwd;

  // A start in IDLE/DONE wins over a same-cycle scan bit, which is then dropped.
  assign start_ok = cfg_start && (state == IDLE || state == DONE);
  assign mode_wr  = (state == MODE) && scan_en;
  assign lut_wr   = (state == LUT) && scan_en;
  assign lut_last = (lut_addr == '1);
  assign ble_last = (ble_idx == IW'(BLE_NUM-1));
  assign fwd      = (state == DONE) && scan_en && !cfg_start;

  assign cfg_busy = (state == MODE) || (state == LUT);
  assign cfg_done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cfg_start) state_nx = MODE;
      MODE:    if (scan_en)   state_nx = LUT;
      LUT:     if (scan_en && lut_last) state_nx = ble_last ? DONE : MODE;
      DONE:    if (cfg_start) state_nx = MODE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ble_idx     <= '0;
      lut_addr    <= '0;
      ble_waddr   <= '0;
      ble_wdata   <= 1'b0;
      scan_out    <= 1'b0;
      scan_out_en <= 1'b0;
    end else begin
      scan_out_en <= fwd;
      if (fwd) scan_out <= scan_in;
      if (start_ok) begin
        ble_idx  <= '0;
        lut_addr <= '0;
      end else if (lut_wr) begin
        ble_waddr <= lut_addr;
        ble_wdata <= scan_in;
        lut_addr  <= lut_addr + 1'b1;
        if (lut_last && !ble_last) ble_idx <= ble_idx + 1'b1;
      end
    end
  end

  genvar i;
  generate
    for (i = 0; i < BLE_NUM; i++) begin : g_ble
      clb_cfg_ble_slot u_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .sel     (ble_idx == IW'(i)),
        .mode_wr (mode_wr),
        .lut_wr  (lut_wr),
        .bit_in  (scan_in),
        .is_comb (is_comb[i]),
        .we      (ble_we[i])
      );
    end
  endgenerate
endmodule

// File: tb/tb_clb_cfg_loader.sv
// Directed bench for clb_cfg_loader: vector tables for idle/bypass, scripted passes.

module tb_clb_cfg_loader;
  localparam int LW = 4;
  localparam int BN = 10;

  logic          clk = 1'b0;
  logic          rst_n, cfg_start, scan_in, scan_en;
  logic          scan_out, scan_out_en, ble_wdata, cfg_busy, cfg_done;
  logic [BN-1:0] ble_we, is_comb;
  logic [LW-1:0] ble_waddr;

  int n_chk  = 0;
  int n_pass = 0;

  clb_cfg_loader #(.LUT_WIDTH(LW), .BLE_NUM(BN)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .scan_in(scan_in),
    .scan_en(scan_en), .scan_out(scan_out), .scan_out_en(scan_out_en),
    .ble_we(ble_we), .ble_waddr(ble_waddr), .ble_wdata(ble_wdata),
    .is_comb(is_comb), .cfg_busy(cfg_busy), .cfg_done(cfg_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic          rst_n, start, en, din;
    logic [BN-1:0] we;
    logic          busy, done, so, soen;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Apply inputs for one clock, then release them 1 time unit after the edge.
  task automatic cyc(input logic st, input logic en, input logic b);
    cfg_start = st; scan_en = en; scan_in = b;
    @(posedge clk); #1;
    cfg_start = 1'b0; scan_en = 1'b0; scan_in = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(1'b0, 1'b1, 1'b1);
    rst_n = 1'b1;
    chk("reset_outputs",
        {ble_we, ble_waddr, ble_wdata, is_comb, cfg_busy, cfg_done, scan_out, scan_out_en},
        '0);
  endtask

  task automatic run_vec(input int i);
    rst_n = tbl[i].rst_n;
    cyc(tbl[i].start, tbl[i].en, tbl[i].din);
    rst_n = 1'b1;
    chk(tbl[i].name, {ble_we, cfg_busy, cfg_done, scan_out, scan_out_en},
        {tbl[i].we, tbl[i].busy, tbl[i].done, tbl[i].so, tbl[i].soen});
  endtask

  // One full pass. Stimulus: mode bit k[0], LUT bit a[0]^k[0] (or all zeros).
  task automatic full_pass(input bit zero, input bit gaps);
    logic b;
    logic [BN-1:0] exp_comb;
    exp_comb = '0;
    cyc(1'b1, 1'b0, 1'b0);
    chk("start_busy", {cfg_busy, cfg_done, ble_we}, {2'b10, {BN{1'b0}}});
    for (int k = 0; k < BN; k++) begin
      b = zero ? 1'b0 : k[0];
      exp_comb[k] = b;
      cyc(1'b0, 1'b1, b);
      chk("mode_no_write", ble_we, '0);
      if (gaps) begin cyc(1'b0, 1'b0, 1'b1); chk("gap_no_write", ble_we, '0); end
      for (int a = 0; a < (1 << LW); a++) begin
        b = zero ? 1'b0 : (a[0] ^ k[0]);
        cyc(1'b0, 1'b1, b);
        chk($sformatf("write_b%0d_a%0d", k, a), {ble_we, ble_waddr, ble_wdata},
            {BN'(1 << k), LW'(a), b});
        if (k == BN-1 && a == (1 << LW)-1)
          chk("done_on_last_write", {cfg_busy, cfg_done}, 2'b01);
        else if (a == (1 << LW)-1)
          chk("busy_ble_end", {cfg_busy, cfg_done}, 2'b10);
        if (gaps) begin cyc(1'b0, 1'b0, 1'b0); chk("gap_no_write", ble_we, '0); end
      end
    end
    chk("is_comb", is_comb, exp_comb);
    cyc(1'b0, 1'b0, 1'b0);
    chk("done_held", {ble_we, cfg_busy, cfg_done}, {{BN{1'b0}}, 2'b01});
  endtask

  initial begin
    //            name            rst  st  en  din  we   busy done so soen
    tbl[0] = '{"idle_en1",        1, 0, 1, 1, '0, 0, 0, 0, 0};
    tbl[1] = '{"idle_en0",        1, 0, 0, 0, '0, 0, 0, 0, 0};
    tbl[2] = '{"idle_en1b",       1, 0, 1, 1, '0, 0, 0, 0, 0};
    tbl[3] = '{"idle_en1c",       1, 0, 1, 0, '0, 0, 0, 0, 0};
    tbl[4] = '{"idle_en1d",       1, 0, 1, 1, '0, 0, 0, 0, 0};
    tbl[5] = '{"bypass_1",        1, 0, 1, 1, '0, 0, 1, 1, 1};
    tbl[6] = '{"bypass_0",        1, 0, 1, 0, '0, 0, 1, 0, 1};
    tbl[7] = '{"bypass_1b",       1, 0, 1, 1, '0, 0, 1, 1, 1};
    tbl[8] = '{"bypass_gap_hold", 1, 0, 0, 0, '0, 0, 1, 1, 0};
    tbl[9] = '{"start_eats_bit",  1, 1, 1, 0, '0, 1, 0, 1, 0};

    rst_n = 1'b0; cfg_start = 1'b0; scan_en = 1'b0; scan_in = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 5; i++) run_vec(i);

    full_pass(1'b0, 1'b0);
    for (int i = 5; i < 10; i++) run_vec(i);

    do_reset();
    full_pass(1'b0, 1'b1);
    full_pass(1'b1, 1'b0);

    // Mid-pass: reach BLE 3, address 7; a start there must be ignored.
    cyc(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b1, 1'b1);
      for (int a = 0; a < ((k == 3) ? 7 : 16); a++) cyc(1'b0, 1'b1, 1'b0);
    end
    cyc(1'b1, 1'b1, 1'b1);
    chk("midpass_start_ignored", {ble_we, ble_waddr, ble_wdata, cfg_busy, cfg_done},
        {BN'(1 << 3), 4'd7, 1'b1, 2'b10});
    chk("midpass_is_comb", is_comb, BN'(4'b1111));
    do_reset();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    chk("restart_mode_bit", {is_comb, ble_we}, {BN'(1), {BN{1'b0}}});
    cyc(1'b0, 1'b1, 1'b1);
    chk("restart_first_write", {ble_we, ble_waddr, ble_wdata}, {BN'(1), 4'd0, 1'b1});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/clb_cfg_loader.md
Name: clb_cfg_loader

Overview:
- Serial configuration controller for one CLB: deserializes a scan bitstream and writes it into the LUT SRAMs and mode bits of BLE_NUM BLEs.
- Drives each BLE's write path (set, write address, write data) and holds each BLE's is_comb select.
- Sits between the chip-level scan chain and the CLB's BLE array.
- After configuration completes, it bypasses scan bits to scan_out so CLBs can be daisy-chained.

Parameters:
- LUT_WIDTH, 4, LUT input count; each LUT holds 2^LUT_WIDTH bits.
- BLE_NUM, 10, number of BLEs configured by this loader.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  synchronous active-low reset.
- cfg_start  input  1  one-cycle pulse; begins a configuration pass.
- scan_in  input  1  serial configuration bit.
- scan_en  input  1  scan_in is valid this cycle.
- scan_out  output  1  registered bypass bit for the downstream CLB.
- scan_out_en  output  1  registered qualifier for scan_out.
- ble_we  output  BLE_NUM  one-hot write enable (BLE "set").
- ble_waddr  output  LUT_WIDTH  LUT address being written.
- ble_wdata  output  1  LUT bit being written.
- is_comb  output  BLE_NUM  per-BLE mode: 1 = combinational output, 0 = registered output.
- cfg_busy  output  1  pass in progress.
- cfg_done  output  1  pass complete; held high until the next cfg_start or reset.

Behaviour:
- Reset (rst_n=0 at posedge): all outputs clear to 0 (ble_we, ble_waddr, ble_wdata, is_comb, cfg_busy, cfg_done, scan_out, scan_out_en); FSM returns to IDLE; counters clear.
- Reset mid-pass: the pass is abandoned; partial LUT contents are left as written.
- Bit order per BLE, BLE 0 first: 1 mode bit, then 2^LUT_WIDTH LUT bits for address 0 upward.
- Bits per BLE = 1 + 2^LUT_WIDTH (17 at default). Total bits = BLE_NUM × that (170 at default).
- Only cycles with scan_en=1 consume a bit. Gaps of any length are allowed and do not change state.
- FSM states: IDLE, MODE, LUT, DONE.
  - IDLE: cfg_start -> MODE; ble_idx=0, lut_addr=0, cfg_busy=1, cfg_done=0.
  - MODE: on scan_en, is_comb[ble_idx] <= scan_in -> LUT.
  - LUT: on scan_en, the next cycle drives ble_we = one-hot(ble_idx), ble_waddr = lut_addr, ble_wdata = scan_in for exactly one cycle.
    - lut_addr increments.
    - At lut_addr = 2^LUT_WIDTH-1: lut_addr wraps to 0. If ble_idx = BLE_NUM-1 -> DONE; else ble_idx++ -> MODE.
  - DONE: cfg_busy=0, cfg_done=1. Each scan_en bit appears on scan_out/scan_out_en one cycle later. cfg_start -> MODE, as from IDLE.
- Write latency: the accepted bit produces its write exactly 1 cycle later. Back-to-back scan_en produces back-to-back writes. ble_we is 0 in all other cycles.
- The last LUT write of the pass coincides with the first DONE cycle, so cfg_done and the final ble_we are both high in that cycle.
- scan_out_en=0 and scan_out holds its last value in IDLE/MODE/LUT; bits are never forwarded during a pass.
- cfg_start while cfg_busy=1 is ignored.
- scan_en in IDLE is ignored, with no forwarding.
- cfg_start and scan_en in the same IDLE/DONE cycle: start is taken; that bit is not consumed and not forwarded.
- is_comb bits persist across passes until overwritten or reset.
- Counter widths: ble_idx = clog2(BLE_NUM); lut_addr = LUT_WIDTH bits plus terminal detect. No overflow is possible.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, cfg_busy=0, cfg_done=0. Drive scan_en=1 -> no ble_we, scan_out_en stays 0.
- Full pass at default parameters, continuous scan_en:
  - Stimulus: BLE k mode bit = k[0]; LUT bit a = a[0]^k[0].
  - Response: 160 single-cycle writes, each with correct one-hot ble_we, ble_waddr, ble_wdata.
  - Response: is_comb = 10'b1010101010.
  - Response: cfg_done asserts on the cycle after the 170th bit.
- Same pass with scan_en toggling 1/0 -> identical write sequence, each write 1 cycle after its accepted bit, none during gaps.
- After DONE, send bits 1,0,1 -> scan_out 1,0,1 with scan_out_en=1, each 1 cycle delayed. ble_we stays 0.
- Mid-pass (BLE 3, address 7):
  - cfg_start pulse -> ignored, sequence continues.
  - rst_n=0 for 1 cycle -> IDLE, all outputs 0. New pass restarts at BLE 0, mode bit.
- Second pass with all-zero stream -> is_comb=0, all 160 writes carry ble_wdata=0, cfg_done re-asserts.
